// File: rtl/map_rom_arbiter.sv
// Map ROM arbiter: pixel priority, round-robin collision lookups, starvation override.
// Result at arb cycle +2+ROM_LAT; no backpressure: collision reqs wait, pixel reqs may be dropped (pix_miss).
module map_rom_arbiter #(
  parameter int         ROM_LAT      = 1,
  parameter int         STARVE_LIMIT = 8,
  parameter logic [3:0] WALL_IDX     = 4'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_req,
  input  logic [16:0] pix_addr,
  output logic        pix_valid,
  output logic [3:0]  pix_color,
  output logic        pix_miss,
  input  logic        girl_req,
  input  logic [9:0]  girl_x,
  input  logic [9:0]  girl_y,
  output logic        girl_gnt,
  output logic        girl_valid,
  output logic [3:0]  girl_color,
  output logic        girl_wall,
  input  logic        boy_req,
  input  logic [9:0]  boy_x,
  input  logic [9:0]  boy_y,
  output logic        boy_gnt,
  output logic        boy_valid,
  output logic [3:0]  boy_color,
  output logic        boy_wall,
  output logic [16:0] rom_addr,
  input  logic [3:0]  rom_data
);

  localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);
  localparam logic [1:0] ID_PIX  = 2'd0;
  localparam logic [1:0] ID_GIRL = 2'd1;
  localparam logic [1:0] ID_BOY  = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
    logic       oob;
  } tag_t;

  // Screen pixels are 640x480, the map is 200x150: scale by 5/16 per axis.
  function automatic logic [16:0] map_addr(input logic [9:0] x, input logic [9:0] y);
    logic [12:0] x5;
    logic [12:0] y5;
    x5 = 13'(x) * 13'd5;
    y5 = 13'(y) * 13'd5;
    return 17'(x5[12:4]) + 17'(y5[12:4]) * 17'd200;
  endfunction

  tag_t       tag_q [0:ROM_LAT];
  tag_t       next_tag;
  tag_t       ret;
  logic [16:0] next_addr;
  logic       rr_boy;
  logic       girl_mask, boy_mask;
  logic [7:0] girl_cnt, boy_cnt;
  logic       girl_elig, boy_elig;
  logic       girl_starve, boy_starve;
  logic       girl_oob, boy_oob;
  logic       sel_pix, sel_girl, sel_boy, miss;
  logic [3:0] ret_color;
  logic       ret_wall;

  assign girl_oob    = (girl_x >= 10'd640) || (girl_y >= 10'd480);
  assign boy_oob     = (boy_x >= 10'd640) || (boy_y >= 10'd480);
  assign girl_elig   = girl_req && !girl_mask;
  assign boy_elig    = boy_req && !boy_mask;
  assign girl_starve = girl_elig && (girl_cnt == LIMIT);
  assign boy_starve  = boy_elig && (boy_cnt == LIMIT);

  always_comb begin
    sel_pix  = 1'b0;
    sel_girl = 1'b0;
    sel_boy  = 1'b0;
    miss     = 1'b0;
    if (girl_starve || boy_starve) begin
      if (girl_starve && boy_starve) begin
        sel_girl = !rr_boy;
        sel_boy  = rr_boy;
      end else begin
        sel_girl = girl_starve;
        sel_boy  = boy_starve;
      end
      miss = pix_req;
    end else if (pix_req) begin
      sel_pix = 1'b1;
    end else if (girl_elig && boy_elig) begin
      sel_girl = !rr_boy;
      sel_boy  = rr_boy;
    end else begin
      sel_girl = girl_elig;
      sel_boy  = boy_elig;
    end
  end

  always_comb begin
    next_tag  = '0;
    next_addr = rom_addr;
    if (sel_pix) begin
      next_tag  = '{vld: 1'b1, id: ID_PIX, oob: 1'b0};
      next_addr = pix_addr;
    end else if (sel_girl) begin
      next_tag  = '{vld: 1'b1, id: ID_GIRL, oob: girl_oob};
      next_addr = girl_oob ? 17'd0 : map_addr(girl_x, girl_y);
    end else if (sel_boy) begin
      next_tag  = '{vld: 1'b1, id: ID_BOY, oob: boy_oob};
      next_addr = boy_oob ? 17'd0 : map_addr(boy_x, boy_y);
    end
  end

  assign ret       = tag_q[ROM_LAT];
  assign ret_color = ret.oob ? 4'd0 : rom_data;
  assign ret_wall  = ret.oob || (rom_data == WALL_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr   <= '0;
      pix_valid  <= 1'b0;
      pix_color  <= '0;
      pix_miss   <= 1'b0;
      girl_gnt   <= 1'b0;
      girl_valid <= 1'b0;
      girl_color <= '0;
      girl_wall  <= 1'b0;
      boy_gnt    <= 1'b0;
      boy_valid  <= 1'b0;
      boy_color  <= '0;
      boy_wall   <= 1'b0;
      rr_boy     <= 1'b0;
      girl_mask  <= 1'b0;
      boy_mask   <= 1'b0;
      girl_cnt   <= '0;
      boy_cnt    <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      rom_addr <= next_addr;
      girl_gnt <= sel_girl;
      boy_gnt  <= sel_boy;
      pix_miss <= miss;
      if (sel_girl || sel_boy) rr_boy <= sel_girl;

      tag_q[0] <= next_tag;
      for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];

      // One outstanding lookup per requester; re-eligible the cycle after its result.
      if (sel_girl)        girl_mask <= 1'b1;
      else if (girl_valid) girl_mask <= 1'b0;
      if (sel_boy)         boy_mask  <= 1'b1;
      else if (boy_valid)  boy_mask  <= 1'b0;

      if (!girl_req || sel_girl)           girl_cnt <= '0;
      else if (girl_elig && girl_cnt != LIMIT) girl_cnt <= girl_cnt + 8'd1;
      if (!boy_req || sel_boy)             boy_cnt  <= '0;
      else if (boy_elig && boy_cnt != LIMIT)   boy_cnt  <= boy_cnt + 8'd1;

      pix_valid  <= ret.vld && (ret.id == ID_PIX);
      girl_valid <= ret.vld && (ret.id == ID_GIRL);
      boy_valid  <= ret.vld && (ret.id == ID_BOY);
      if (ret.vld && ret.id == ID_PIX) pix_color <= rom_data;
      if (ret.vld && ret.id == ID_GIRL) begin
        girl_color <= ret_color;
        girl_wall  <= ret_wall;
      end
      if (ret.vld && ret.id == ID_BOY) begin
        boy_color <= ret_color;
        boy_wall  <= ret_wall;
      end
    end
  end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a 1-cycle ROM model and an in-order result scoreboard.
module tb_map_rom_arbiter;

  localparam int ROM_LAT = 1;
  localparam int LAT     = ROM_LAT + 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_req;
  logic [16:0] pix_addr;
  logic        pix_valid, pix_miss;
  logic [3:0]  pix_color;
  logic        girl_req, girl_gnt, girl_valid, girl_wall;
  logic [9:0]  girl_x, girl_y;
  logic [3:0]  girl_color;
  logic        boy_req, boy_gnt, boy_valid, boy_wall;
  logic [9:0]  boy_x, boy_y;
  logic [3:0]  boy_color;
  logic [16:0] rom_addr;
  logic [3:0]  rom_data;

  typedef struct {
    int         id;
    logic [3:0] color;
    logic       wall;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  map_rom_arbiter #(.ROM_LAT(ROM_LAT), .STARVE_LIMIT(8), .WALL_IDX(4'd4)) dut (
    .Clk(Clk), .Reset(Reset),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_color(pix_color), .pix_miss(pix_miss),
    .girl_req(girl_req), .girl_x(girl_x), .girl_y(girl_y), .girl_gnt(girl_gnt),
    .girl_valid(girl_valid), .girl_color(girl_color), .girl_wall(girl_wall),
    .boy_req(boy_req), .boy_x(boy_x), .boy_y(boy_y), .boy_gnt(boy_gnt),
    .boy_valid(boy_valid), .boy_color(boy_color), .boy_wall(boy_wall),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [3:0] rom_fn(input logic [16:0] a);
    if (a == 17'd15100) return 4'd4;
    return a[3:0] + a[7:4] + 4'd3;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  function automatic logic [16:0] addr_of(input int x, input int y);
    return 17'((x * 5) / 16 + ((y * 5) / 16) * 200);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input logic [16:0] a);
    exp_t e;
    e.id = 0; e.color = rom_fn(a); e.wall = 1'b0; e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic push_col(input int id, input int x, input int y);
    exp_t e;
    logic [3:0] c;
    if (x >= 640 || y >= 480) begin
      e.color = 4'd0; e.wall = 1'b1;
    end else begin
      c = rom_fn(addr_of(x, y));
      e.color = c; e.wall = (c == 4'd4);
    end
    e.id = id; e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic check_pop(input int id, input logic [3:0] color, input logic wall);
    exp_t e;
    chk("sb_pending", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("res_id", 32'(id), 32'(e.id));
      chk("res_color", 32'(color), 32'(e.color));
      if (id != 0) chk("res_wall", 32'(wall), 32'(e.wall));
      chk("res_cycle", 32'(cyc), 32'(e.due));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    chk("valid_onehot", 32'($countones({pix_valid, girl_valid, boy_valid}) <= 1), 1);
    if (pix_valid)  check_pop(0, pix_color, 1'b0);
    if (girl_valid) check_pop(1, girl_color, girl_wall);
    if (boy_valid)  check_pop(2, boy_color, boy_wall);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_outs"}, 32'({pix_valid, pix_color, pix_miss,
                             girl_gnt, girl_valid, girl_color, girl_wall,
                             boy_gnt, boy_valid, boy_color, boy_wall}), 0);
  endtask

  initial begin
    Reset = 1'b1; pix_req = 1'b0; pix_addr = '0;
    girl_req = 1'b0; girl_x = '0; girl_y = '0;
    boy_req = 1'b0; boy_x = '0; boy_y = '0;
    tick(); tick();
    chk_all_zero("reset");

    // Reset while a girl lookup is in flight drops its result.
    Reset = 1'b0;
    tick();
    girl_req = 1'b1; girl_x = 10'd320; girl_y = 10'd240;
    tick();
    chk("mid_gnt", 32'(girl_gnt), 1);
    chk("mid_addr", 32'(rom_addr), 15100);
    girl_req = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    Reset = 1'b0;
    repeat (4) tick();

    // Pixel only.
    pix_req = 1'b1; pix_addr = 17'd15100; push_pix(17'd15100);
    tick();
    pix_req = 1'b0;
    chk("pix_addr", 32'(rom_addr), 15100);
    chk("pix_nomiss", 32'(pix_miss), 0);
    tick(); tick();
    chk("pix_valid", 32'(pix_valid), 1);
    chk("pix_color", 32'(pix_color), 4);
    tick();

    // Girl coordinate conversion, centre then far corner.
    girl_req = 1'b1; girl_x = 10'd320; girl_y = 10'd240; push_col(1, 320, 240);
    tick();
    girl_req = 1'b0;
    chk("girl_gnt", 32'(girl_gnt), 1);
    chk("girl_addr", 32'(rom_addr), 15100);
    tick(); tick();
    chk("girl_valid", 32'(girl_valid), 1);
    chk("girl_wall", 32'(girl_wall), 1);
    tick();
    girl_req = 1'b1; girl_x = 10'd639; girl_y = 10'd479; push_col(1, 639, 479);
    tick();
    girl_req = 1'b0;
    chk("corner_gnt", 32'(girl_gnt), 1);
    chk("corner_addr", 32'(rom_addr), 29999);
    repeat (3) tick();

    // Round-robin: the last collision grant went to girl, so boy leads.
    girl_req = 1'b1; girl_x = 10'd16;  girl_y = 10'd16;
    boy_req  = 1'b1; boy_x  = 10'd100; boy_y  = 10'd50;
    for (int k = 0; k < 10; k++) begin
      if (k % 4 == 0) push_col(2, 100, 50);
      else if (k % 4 == 1) push_col(1, 16, 16);
      tick();
      chk("rr_girl_gnt", 32'(girl_gnt), 32'(k % 4 == 1));
      chk("rr_boy_gnt", 32'(boy_gnt), 32'(k % 4 == 0));
      if (k % 4 < 2) chk("rr_addr", 32'(rom_addr), (k % 4 == 0) ? 3031 : 1005);
    end
    girl_req = 1'b0; boy_req = 1'b0;
    repeat (4) tick();

    // Starvation: continuous pixel traffic, boy forces through every 8 waits.
    pix_req = 1'b1; boy_req = 1'b1; boy_x = 10'd200; boy_y = 10'd100;
    for (int k = 0; k < 22; k++) begin
      pix_addr = 17'(1000 + k);
      if (k == 8 || k == 20) push_col(2, 200, 100);
      else push_pix(17'(1000 + k));
      tick();
      chk("st_boy_gnt", 32'(boy_gnt), 32'(k == 8 || k == 20));
      chk("st_miss", 32'(pix_miss), 32'(k == 8 || k == 20));
      if (k == 8) chk("st_addr", 32'(rom_addr), 6262);
    end
    pix_req = 1'b0; boy_req = 1'b0;
    repeat (4) tick();

    // Out of bounds.
    girl_req = 1'b1; girl_x = 10'd700; girl_y = 10'd10; push_col(1, 700, 10);
    tick();
    girl_req = 1'b0;
    chk("oob_gnt", 32'(girl_gnt), 1);
    chk("oob_addr", 32'(rom_addr), 0);
    tick(); tick();
    chk("oob_valid", 32'(girl_valid), 1);
    chk("oob_wall", 32'(girl_wall), 1);
    chk("oob_color", 32'(girl_color), 0);
    tick();
    boy_req = 1'b1; boy_x = 10'd10; boy_y = 10'd480; push_col(2, 10, 480);
    tick();
    boy_req = 1'b0;
    chk("oob_boy_gnt", 32'(boy_gnt), 1);
    repeat (4) tick();

    // Withdrawal before grant: no grant, no result.
    pix_req = 1'b1; girl_req = 1'b1; girl_x = 10'd40; girl_y = 10'd40;
    for (int k = 0; k < 3; k++) begin
      pix_addr = 17'(500 + k);
      push_pix(17'(500 + k));
      tick();
      chk("wd_gnt", 32'(girl_gnt), 0);
    end
    pix_req = 1'b0; girl_req = 1'b0;
    repeat (2) tick();
    chk("wd_after_gnt", 32'(girl_gnt), 0);
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
